// File: rtl/apb_bridge_ctrl.sv
// APB-side sequencer of the AHB-to-APB bridge: runs APB SETUP/ENABLE phases for
// qualified AHB transfers, stalls the AHB master through hreadyout, returns read
// data and turns APB slave errors or timeouts into a two-cycle AHB ERROR response.
module apb_bridge_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NSEL       = 3,
    parameter int WAIT_MAX   = 16
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  valid,
    input  logic                  hwrite,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic [NSEL-1:0]       tempselx,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic [NSEL-1:0]       pselx,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata
);

    // Counter is at least one bit wide so WAIT_MAX=0 (timeout disabled) still elaborates.
    localparam int WCW         = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam int WAIT_SAT_I  = (WAIT_MAX > 0) ? WAIT_MAX : 1;
    localparam int WAIT_LAST_I = (WAIT_MAX > 0) ? WAIT_MAX - 1 : 0;
    localparam logic [WCW-1:0] WAIT_SAT  = WCW'(WAIT_SAT_I);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_LAST_I);

    typedef enum logic [2:0] {
        IDLE, WWAIT, RSETUP, RENABLE, WSETUP, WENABLE, ERROR
    } state_t;

    state_t          state, state_next;
    logic [NSEL-1:0] sel_q;
    logic [WCW-1:0]  wait_cnt;
    logic            err_q;
    logic            in_enable;
    logic            timeout;

    assign in_enable = (state == RENABLE) || (state == WENABLE);
    // The wait_cnt-th stalled cycle has just elapsed when it reaches WAIT_MAX-1 with pready low.
    assign timeout   = (WAIT_MAX != 0) && !pready && (wait_cnt == WAIT_LAST);

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge hclk) begin
        if (hreset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode.
    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (valid) state_next = hwrite ? WWAIT : RSETUP;
            WWAIT:   state_next = WSETUP;
            RSETUP:  state_next = (sel_q == '0) ? ERROR : RENABLE;
            WSETUP:  state_next = (sel_q == '0) ? ERROR : WENABLE;
            RENABLE, WENABLE: begin
                if (pready)       state_next = pslverr ? ERROR : IDLE;
                else if (timeout) state_next = ERROR;
            end
            ERROR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Transfer attribute capture, write data, read data return and error flag.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            sel_q  <= '0;
            paddr  <= '0;
            pwrite <= 1'b0;
            pwdata <= '0;
            hrdata <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == IDLE && valid) begin
                paddr  <= haddr;
                sel_q  <= tempselx;
                pwrite <= hwrite;
            end
            if (state == WWAIT)
                pwdata <= hwdata;
            if (state == RENABLE && pready && !pslverr)
                hrdata <= prdata;
            err_q <= (state == ERROR);
        end
    end

    // ENABLE-phase wait counter: zero outside ENABLE, counts stalled cycles, saturates.
    always_ff @(posedge hclk) begin
        if (hreset || !in_enable)               wait_cnt <= '0;
        else if (!pready && wait_cnt != WAIT_SAT) wait_cnt <= wait_cnt + 1'b1;
    end

    // Moore output decode from the state register.
    always_comb begin
        hreadyout = (state == IDLE);
        hresp     = (state == ERROR) || err_q;
        penable   = in_enable;
        pselx     = '0;
        if (state == RSETUP || state == WSETUP || in_enable)
            pselx = sel_q;
    end

endmodule

// File: tb/tb_apb_bridge_ctrl.sv
// Directed self-checking bench for apb_bridge_ctrl (instantiated with WAIT_MAX=4).
module tb_apb_bridge_ctrl;

    logic        hclk = 1'b0;
    logic        hreset, valid, hwrite, pready, pslverr;
    logic [31:0] haddr, hwdata, prdata, hrdata, paddr, pwdata;
    logic [2:0]  tempselx, pselx;
    logic        hreadyout, hresp, penable, pwrite;

    int checks   = 0;
    int failures = 0;

    apb_bridge_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NSEL(3), .WAIT_MAX(4)) dut (
        .hclk(hclk), .hreset(hreset), .valid(valid), .hwrite(hwrite), .haddr(haddr),
        .hwdata(hwdata), .tempselx(tempselx), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
        .pselx(pselx), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are settled 2 time units after the edge.
    task automatic step();
        @(posedge hclk);
        #2;
    endtask

    initial begin
        int low_cnt, pen_cnt;
        logic done;
        hreset = 1'b1; valid = 1'b0; hwrite = 1'b0; haddr = '0; hwdata = '0;
        tempselx = '0; prdata = '0; pready = 1'b1; pslverr = 1'b0;

        // 1: reset
        step(); step();
        hreset = 1'b0;
        check("rst_hreadyout", 32'(hreadyout), 32'd1);
        check("rst_hresp",     32'(hresp),     32'd0);
        check("rst_pselx",     32'(pselx),     32'd0);
        check("rst_penable",   32'(penable),   32'd0);
        check("rst_paddr",     paddr,          32'h0);
        check("rst_hrdata",    hrdata,         32'h0);

        // 2: zero-wait read
        valid = 1'b1; hwrite = 1'b0; haddr = 32'h8000_0010; tempselx = 3'b001;
        prdata = 32'hCAFE_F00D; pready = 1'b1;
        step(); valid = 1'b0;
        check("rd_setup_pselx",   32'(pselx),     32'h1);
        check("rd_setup_penable", 32'(penable),   32'd0);
        check("rd_setup_hready",  32'(hreadyout), 32'd0);
        check("rd_paddr",         paddr,          32'h8000_0010);
        step();
        check("rd_enable_penable", 32'(penable), 32'd1);
        step();
        check("rd_done_hready", 32'(hreadyout), 32'd1);
        check("rd_done_hrdata", hrdata,         32'hCAFE_F00D);
        check("rd_done_pselx",  32'(pselx),     32'h0);

        // 3: write with two wait states
        valid = 1'b1; hwrite = 1'b1; haddr = 32'h8400_0004; tempselx = 3'b010; pready = 1'b0;
        step(); valid = 1'b0; hwdata = 32'h1234_5678;
        low_cnt = 0; pen_cnt = 0; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (hreadyout) done = 1'b1;
            else begin
                low_cnt++;
                if (penable) pen_cnt++;
                pready = (pen_cnt >= 3);
                step();
            end
        end
        check("wr_completed",    32'(done),    32'd1);
        check("wr_hready_low",   32'(low_cnt), 32'd5);
        check("wr_phase_len",    32'(low_cnt + 1), 32'd6);
        check("wr_penable_cyc",  32'(pen_cnt), 32'd3);
        check("wr_pwrite",       32'(pwrite),  32'd1);
        check("wr_pwdata",       pwdata,       32'h1234_5678);
        check("wr_paddr",        paddr,        32'h8400_0004);
        pready = 1'b1;

        // 4: slave error on read
        valid = 1'b1; hwrite = 1'b0; haddr = 32'h8800_0000; tempselx = 3'b100;
        prdata = 32'hDEAD_BEEF; pslverr = 1'b1;
        step(); valid = 1'b0;
        check("se_setup_pselx", 32'(pselx), 32'h4);
        step();
        check("se_enable", 32'(penable), 32'd1);
        step();
        check("se_err_hready", 32'(hreadyout), 32'd0);
        check("se_err_hresp",  32'(hresp),     32'd1);
        check("se_err_pselx",  32'(pselx),     32'h0);
        pslverr = 1'b0;
        step();
        check("se_idle_hready", 32'(hreadyout), 32'd1);
        check("se_idle_hresp",  32'(hresp),     32'd1);
        step();
        check("se_after_hresp", 32'(hresp), 32'd0);
        check("se_hrdata_held", hrdata,     32'hCAFE_F00D);

        // 5: timeout with pready stuck low
        valid = 1'b1; hwrite = 1'b0; haddr = 32'h8000_0020; tempselx = 3'b001; pready = 1'b0;
        step(); valid = 1'b0;
        pen_cnt = 0; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            if (hresp) done = 1'b1;
            else if (penable) pen_cnt++;
        end
        check("to_reached_error", 32'(done),      32'd1);
        check("to_enable_cycles", 32'(pen_cnt),   32'd4);
        check("to_err_pselx",     32'(pselx),     32'h0);
        check("to_err_hready",    32'(hreadyout), 32'd0);
        pready = 1'b1;
        step();
        check("to_idle_hresp",  32'(hresp),     32'd1);
        check("to_idle_hready", 32'(hreadyout), 32'd1);
        step();
        check("to_after_hresp", 32'(hresp), 32'd0);

        // No slave decoded: straight to ERROR without an APB access
        valid = 1'b1; hwrite = 1'b0; haddr = 32'h9000_0000; tempselx = 3'b000;
        step(); valid = 1'b0;
        check("nd_setup_pselx", 32'(pselx), 32'h0);
        step();
        check("nd_err_hresp",   32'(hresp),   32'd1);
        check("nd_err_penable", 32'(penable), 32'd0);
        step(); step();

        // 6: reset during WENABLE
        valid = 1'b1; hwrite = 1'b1; haddr = 32'h8400_0008; tempselx = 3'b010; pready = 1'b0;
        step(); valid = 1'b0; hwdata = 32'h0BAD_0BAD;
        step(); step();
        check("rw_in_enable", 32'(penable), 32'd1);
        hreset = 1'b1;
        step();
        hreset = 1'b0; pready = 1'b1;
        check("rw_pselx",  32'(pselx),     32'h0);
        check("rw_penable",32'(penable),   32'd0);
        check("rw_hresp",  32'(hresp),     32'd0);
        check("rw_hready", 32'(hreadyout), 32'd1);

        // Back-to-back read then write
        valid = 1'b1; hwrite = 1'b0; haddr = 32'h8000_0030; tempselx = 3'b001; prdata = 32'h1111_2222;
        step(); valid = 1'b0;
        check("bb_rd_pselx", 32'(pselx), 32'h1);
        step(); step();
        check("bb_rd_hready", 32'(hreadyout), 32'd1);
        check("bb_rd_hrdata", hrdata,         32'h1111_2222);
        valid = 1'b1; hwrite = 1'b1; haddr = 32'h8800_0040; tempselx = 3'b100;
        step(); valid = 1'b0; hwdata = 32'hAAAA_5555;
        check("bb_wr_accept", 32'(hreadyout), 32'd0);
        step();
        check("bb_wr_pselx",  32'(pselx), 32'h4);
        check("bb_wr_pwdata", pwdata,     32'hAAAA_5555);
        check("bb_wr_paddr",  paddr,      32'h8800_0040);
        step();
        check("bb_wr_enable", 32'(penable), 32'd1);
        step();
        check("bb_wr_done",  32'(hreadyout), 32'd1);
        check("bb_wr_hresp", 32'(hresp),     32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
